lr35902_oam_scan: RTL and testbench
===================================

Name: lr35902_oam_scan

Overview:
- PPU mode-2 sprite search engine. It is the read-side master for the OAM RAM.
- It walks all 40 OAM entries through the OAM's 16-bit registered read port and compares each entry's Y against the current line.
- It stores up to MAX_SPRITES hits, in OAM order, in a small line buffer that the pixel fetcher reads by index.

Parameters:
- MAX_SPRITES, 10, capacity of the per-line hit buffer; further hits are dropped.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a scan; samples ly and obj_size.
- ly  in  8  current line number.
- obj_size  in  1  object height select: 0 = 8 lines, 1 = 16 lines.
- oam_adr  out  8  byte address to OAM; always 4*entry (even, word-aligned).
- oam_read  out  1  OAM read strobe.
- oam_dout16  in  16  OAM word valid the cycle after oam_read; [7:0] = Y byte, [15:8] = X byte.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when a scan completes.
- count  out  4  number of valid buffer entries (0..MAX_SPRITES).
- buf_idx  in  4  buffer read index.
- buf_x  out  8  X byte of the selected entry.
- buf_num  out  6  OAM entry number (0..39) of the selected entry.
- buf_line  out  4  row within the object for ly (0..15).

Behaviour:
- Reset values: oam_adr=0, oam_read=0, busy=0, done=0, count=0, all buffer entries cleared to 0, state IDLE, entry counter=0.
- States:
  - IDLE -> FETCH on start.
  - FETCH -> COMPARE unconditionally.
  - COMPARE -> FETCH if entry<39.
  - COMPARE -> FINISH if entry==39.
  - FINISH -> IDLE.
- On start (any state): latch ly and obj_size, count<=0, entry<=0, busy<=1, state<=FETCH. A start during a scan aborts and restarts it. Buffer contents beyond count are don't-care.
- FETCH: oam_read=1, oam_adr={entry,2'b00}. This output is combinational from state and entry.
- COMPARE: oam_read=0.
  - diff = {1'b0,ly_l} + 9'd16 - {1'b0,Y}, computed 9-bit, mod 512.
  - hit = diff < (obj_size_l ? 16 : 8).
  - If hit and count<MAX_SPRITES: write {X, entry, diff[3:0]} to buffer[count], then count<=count+1.
  - If count==MAX_SPRITES, hits are ignored; count saturates.
  - entry<=entry+1.
- Timing: 2 clocks per entry, 80 clocks for 40 entries.
  - start seen at edge t0; first FETCH cycle is t0+1.
  - Last COMPARE is cycle t0+80. FINISH is cycle t0+81: done=1, busy=0.
  - done is high only in FINISH.
  - busy is high from t0+1 through t0+80 inclusive.
- Buffer read port is combinational from buf_idx. buf_idx >= count returns stale/zero data; consumers must respect count.
- Buffer and count hold after done until the next start or reset.
- ly/obj_size changes during a scan have no effect (latched copies used).
- Reset asserted mid-scan: immediately IDLE, oam_read=0, busy=0, count=0, and no done pulse.
- OAM entries 40..63 are never addressed (max oam_adr = 156).

Test Plan:
- OAM all zero, ly=0, obj_size=0, start -> diff=16, no hits. busy high 80 cycles; done pulse at t0+81; count=0; oam_adr sequence 0,4,...,156, each with oam_read for exactly one cycle.
- Entry 5 Y=16 X=40, others Y=0, ly=0, 8x8 -> count=1; buffer[0] = x=40, num=5, line=0.
- Entries 0..11 all Y=20 with X=entry*8, ly=10 (diff=6) -> count=10 saturated; buffer[k].num=k for k=0..9, line=6; entries 10 and 11 dropped.
- Entry 3 Y=16, ly=12: obj_size=0 -> count=0; obj_size=1 -> count=1, line=12. Then ly=255 with Y=0 -> diff=271, no hit; ly=239 with Y=255 -> diff=0, hit with line 0.
- Assert reset at t0+30 -> busy=0, oam_read=0, count=0 asynchronously and no done pulse. Then release reset and start again -> full 80-cycle scan completes normally.
- Start pulse again at t0+40 during a scan -> scan restarts from entry 0 and count clears; done appears 81 cycles after the second start only.

Source files
------------

// File: rtl/lr35902_oam_scan_if.sv
// Bus bundle between the mode-2 sprite search engine and its neighbours:
// scan control, the OAM read port and the per-line hit buffer read port.
interface lr35902_oam_scan_if;
    logic        start_i;
    logic [7:0]  ly_i;
    logic        obj_size_i;
    logic [7:0]  oam_adr_o;
    logic        oam_read_o;
    logic [15:0] oam_dout16_i;
    logic        busy_o;
    logic        done_o;
    logic [3:0]  count_o;
    logic [3:0]  buf_idx_i;
    logic [7:0]  buf_x_o;
    logic [5:0]  buf_num_o;
    logic [3:0]  buf_line_o;

    modport slave (
        input  start_i, ly_i, obj_size_i, oam_dout16_i, buf_idx_i,
        output oam_adr_o, oam_read_o, busy_o, done_o, count_o,
               buf_x_o, buf_num_o, buf_line_o
    );

    modport master (
        output start_i, ly_i, obj_size_i, oam_dout16_i, buf_idx_i,
        input  oam_adr_o, oam_read_o, busy_o, done_o, count_o,
               buf_x_o, buf_num_o, buf_line_o
    );
endinterface

// File: rtl/lr35902_oam_scan.sv
// PPU mode-2 sprite search: walks the 40 OAM entries two clocks each and
// collects up to MAX_SPRITES Y-hits for the latched line, in OAM order.
module lr35902_oam_scan #(
    parameter int MAX_SPRITES = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    lr35902_oam_scan_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_COMPARE = 2'd2,
        ST_FINISH  = 2'd3
    } state_e;

    localparam logic [3:0] MAX_CNT    = 4'(MAX_SPRITES);
    localparam logic [5:0] LAST_ENTRY = 6'd39;

    state_e     state_q, state_d;
    logic [5:0] entry_q, entry_d;
    logic [3:0] count_q, count_d;
    logic [7:0] ly_q, ly_d;
    logic       size_q, size_d;

    logic [8:0] diff_s;
    logic       hit_s;
    logic       wr_en_s;

    logic [7:0] buf_x_q    [MAX_SPRITES];
    logic [5:0] buf_num_q  [MAX_SPRITES];
    logic [3:0] buf_line_q [MAX_SPRITES];

    // Y match: the OAM Y byte is offset by 16, so the row is ly+16-Y (mod 512)
    always_comb begin
        diff_s = {1'b0, ly_q} + 9'd16 - {1'b0, bus.oam_dout16_i[7:0]};
        hit_s  = (diff_s < (size_q ? 9'd16 : 9'd8));
    end

    // State, entry counter, hit count and latched line parameters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            entry_q <= 6'd0;
            count_q <= 4'd0;
            ly_q    <= 8'd0;
            size_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            count_q <= count_d;
            ly_q    <= ly_d;
            size_q  <= size_d;
        end
    end

    // Next-state logic; a start pulse restarts the scan from any state
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        count_d = count_q;
        ly_d    = ly_q;
        size_d  = size_q;
        wr_en_s = 1'b0;
        if (bus.start_i) begin
            state_d = ST_FETCH;
            entry_d = 6'd0;
            count_d = 4'd0;
            ly_d    = bus.ly_i;
            size_d  = bus.obj_size_i;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_FETCH: begin
                    state_d = ST_COMPARE;
                end
                ST_COMPARE: begin
                    // Once the buffer is full further hits are simply dropped
                    if (hit_s && (count_q < MAX_CNT)) begin
                        wr_en_s = 1'b1;
                        count_d = count_q + 4'd1;
                    end else begin
                        count_d = count_q;
                    end
                    entry_d = entry_q + 6'd1;
                    if (entry_q == LAST_ENTRY) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_FINISH: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Hit buffer, written at slot count_q while comparing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_SPRITES; i++) begin
                buf_x_q[i]    <= 8'd0;
                buf_num_q[i]  <= 6'd0;
                buf_line_q[i] <= 4'd0;
            end
        end else if (wr_en_s) begin
            buf_x_q[count_q]    <= bus.oam_dout16_i[15:8];
            buf_num_q[count_q]  <= entry_q;
            buf_line_q[count_q] <= diff_s[3:0];
        end
    end

    // OAM read port and status decode straight from the state register
    always_comb begin
        bus.oam_read_o = (state_q == ST_FETCH);
        if (state_q == ST_FETCH) begin
            bus.oam_adr_o = {entry_q, 2'b00};
        end else begin
            bus.oam_adr_o = 8'd0;
        end
        bus.busy_o  = (state_q == ST_FETCH) || (state_q == ST_COMPARE);
        bus.done_o  = (state_q == ST_FINISH);
        bus.count_o = count_q;
    end

    // Buffer read port; indices past the buffer read as zero
    always_comb begin
        bus.buf_x_o    = 8'd0;
        bus.buf_num_o  = 6'd0;
        bus.buf_line_o = 4'd0;
        if (bus.buf_idx_i < MAX_CNT) begin
            bus.buf_x_o    = buf_x_q[bus.buf_idx_i];
            bus.buf_num_o  = buf_num_q[bus.buf_idx_i];
            bus.buf_line_o = buf_line_q[bus.buf_idx_i];
        end else begin
            bus.buf_x_o    = 8'd0;
            bus.buf_num_o  = 6'd0;
            bus.buf_line_o = 4'd0;
        end
    end

endmodule

// File: tb/tb_lr35902_oam_scan.sv
// Self-checking bench for lr35902_oam_scan: directed and random OAM images
// compared against a line-hit list computed directly from the Y-match rule.
module tb_lr35902_oam_scan;

    localparam int MAXS = 10;

    logic clk;
    logic reset;

    lr35902_oam_scan_if bus ();

    lr35902_oam_scan #(.MAX_SPRITES(MAXS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    logic [7:0] oam_y [40];
    logic [7:0] oam_x [40];
    logic       bad_adr;

    int exp_n;
    int exp_x    [MAXS];
    int exp_num  [MAXS];
    int exp_line [MAXS];

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // OAM with a registered 16-bit read port
    always @(posedge clk) begin
        if (bus.oam_read_o) begin
            if (bus.oam_adr_o >= 8'd160 || bus.oam_adr_o[1:0] != 2'b00) begin
                bad_adr <= 1'b1;
                bus.oam_dout16_i <= 16'h0000;
            end else begin
                bus.oam_dout16_i <= {oam_x[bus.oam_adr_o >> 2], oam_y[bus.oam_adr_o >> 2]};
            end
        end
    end

    task automatic model(input int ly, input int sz);
        int h;
        int d;
        h = (sz != 0) ? 16 : 8;
        exp_n = 0;
        for (int e = 0; e < 40; e++) begin
            d = (ly + 16 - int'(oam_y[e])) % 512;
            if (d < 0) d += 512;
            if (d < h && exp_n < MAXS) begin
                exp_x[exp_n]    = int'(oam_x[e]);
                exp_num[exp_n]  = e;
                exp_line[exp_n] = d;
                exp_n++;
            end
        end
    endtask

    task automatic clear_oam();
        for (int e = 0; e < 40; e++) begin
            oam_y[e] = 8'd0;
            oam_x[e] = 8'd0;
        end
    endtask

    // Pulse start, then watch 86 cycles of timing and the address sequence
    task automatic run_scan(input string tag, input logic [7:0] ly, input logic sz);
        int busy_cnt;
        int rd_cnt;
        int done_at;
        int done_cnt;
        int cnt0;
        int seq_ok;
        busy_cnt = 0; rd_cnt = 0; done_at = -1; done_cnt = 0; seq_ok = 1; cnt0 = -1;
        bad_adr = 1'b0;
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.ly_i       = ly;
        bus.obj_size_i = sz;
        @(posedge clk);
        #1;
        bus.start_i    = 1'b0;
        bus.ly_i       = 8'($urandom);
        bus.obj_size_i = 1'($urandom);
        for (int j = 0; j < 86; j++) begin
            @(negedge clk);
            if (j == 0) cnt0 = int'(bus.count_o);
            if (bus.busy_o) busy_cnt++;
            if (bus.done_o) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
            end
            if (bus.oam_read_o) begin
                rd_cnt++;
                if ((j % 2) != 0 || int'(bus.oam_adr_o) != 4 * (j / 2)) seq_ok = 0;
            end
        end
        check_eq({tag, " count_clr"}, cnt0, 0);
        check_eq({tag, " busy_cycles"}, busy_cnt, 80);
        check_eq({tag, " read_cycles"}, rd_cnt, 40);
        check_eq({tag, " done_time"}, done_at, 80);
        check_eq({tag, " done_width"}, done_cnt, 1);
        check_eq({tag, " adr_seq"}, seq_ok, 1);
        check_eq({tag, " adr_range"}, int'(bad_adr), 0);
        model(int'(ly), int'(sz));
        check_eq({tag, " count"}, int'(bus.count_o), exp_n);
        for (int k = 0; k < exp_n; k++) begin
            bus.buf_idx_i = 4'(k);
            #1;
            check_eq($sformatf("%s buf%0d_x", tag, k), int'(bus.buf_x_o), exp_x[k]);
            check_eq($sformatf("%s buf%0d_num", tag, k), int'(bus.buf_num_o), exp_num[k]);
            check_eq($sformatf("%s buf%0d_line", tag, k), int'(bus.buf_line_o), exp_line[k]);
        end
    endtask

    initial begin
        int done_seen;
        int cnt_before;
        checks = 0;
        errors = 0;
        bad_adr = 1'b0;
        bus.start_i = 1'b0;
        bus.ly_i = 8'd0;
        bus.obj_size_i = 1'b0;
        bus.buf_idx_i = 4'd0;
        bus.oam_dout16_i = 16'h0000;
        clear_oam();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst busy", int'(bus.busy_o), 0);
        check_eq("rst done", int'(bus.done_o), 0);
        check_eq("rst count", int'(bus.count_o), 0);
        check_eq("rst read", int'(bus.oam_read_o), 0);
        check_eq("rst adr", int'(bus.oam_adr_o), 0);
        check_eq("rst buf_x", int'(bus.buf_x_o), 0);
        reset = 1'b0;
        @(negedge clk);

        run_scan("zero", 8'd0, 1'b0);

        oam_y[5] = 8'd16; oam_x[5] = 8'd40;
        run_scan("single", 8'd0, 1'b0);

        clear_oam();
        for (int e = 0; e < 12; e++) begin
            oam_y[e] = 8'd20;
            oam_x[e] = 8'(e * 8);
        end
        run_scan("sat", 8'd10, 1'b0);

        clear_oam();
        oam_y[3] = 8'd16; oam_x[3] = 8'd77;
        run_scan("h8", 8'd12, 1'b0);
        run_scan("h16", 8'd12, 1'b1);
        oam_y[3] = 8'd0;
        run_scan("wrap", 8'd255, 1'b1);
        oam_y[3] = 8'd255;
        run_scan("top", 8'd239, 1'b0);

        // Reset mid-scan with hits already collected
        clear_oam();
        for (int e = 0; e < 8; e++) oam_y[e] = 8'd30;
        @(negedge clk);
        bus.start_i = 1'b1; bus.ly_i = 8'd20; bus.obj_size_i = 1'b0;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (30) @(negedge clk);
        cnt_before = int'(bus.count_o);
        check_eq("rst_mid precount", int'(cnt_before > 0), 1);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_mid busy", int'(bus.busy_o), 0);
        check_eq("rst_mid read", int'(bus.oam_read_o), 0);
        check_eq("rst_mid count", int'(bus.count_o), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int j = 0; j < 90; j++) begin
            @(negedge clk);
            if (bus.done_o || bus.busy_o) done_seen++;
        end
        check_eq("rst_mid no_done", done_seen, 0);
        run_scan("after_rst", 8'd20, 1'b0);

        // Restart at t0+40: done must only follow the second start
        for (int e = 0; e < 40; e++) begin
            oam_y[e] = 8'($urandom_range(0, 40));
            oam_x[e] = 8'($urandom);
        end
        @(negedge clk);
        bus.start_i = 1'b1; bus.ly_i = 8'd5; bus.obj_size_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        done_seen = 0;
        for (int j = 0; j < 38; j++) begin
            @(negedge clk);
            if (bus.done_o) done_seen++;
        end
        check_eq("restart early_done", done_seen, 0);
        run_scan("restart", 8'd14, 1'b0);

        for (int r = 0; r < 6; r++) begin
            logic [7:0] rly;
            rly = 8'($urandom_range(0, 160));
            for (int e = 0; e < 40; e++) begin
                oam_y[e] = 8'(int'(rly) + $urandom_range(0, 40));
                oam_x[e] = 8'($urandom);
            end
            run_scan($sformatf("rnd%0d", r), rly, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
